// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control slice: sequencer states,
// the hard-wired zero register and the default halt drain length.
package ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_e;

   localparam logic [4:0] REG_ZERO             = 5'd0;
   localparam int         DEFAULT_DRAIN_CYCLES = 3;

   // True when a live source operand names a real (non-zero) destination.
   function automatic logic reg_match(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return uses && (src == dst) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification for the instruction in ID:
// load-use, branch/jump-register operand dependence, and PC redirect.
module hazard_detect
   import ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       id_branch,
   input  logic       id_branch_taken,
   input  logic       id_jump,
   input  logic       id_jumpr,
   input  logic       ex_regwrite,
   input  logic       ex_memread,
   input  logic [4:0] ex_wreg,
   input  logic       mem_memread,
   input  logic [4:0] mem_wreg,
   output logic       hz_lu,
   output logic       hz_br,
   output logic       redirect
);

   logic ex_dep_s;
   logic mem_dep_s;

   // Operand dependence of the ID instruction on the EX and MEM destinations.
   always_comb begin
      ex_dep_s  = reg_match(id_uses_rs, id_rs, ex_wreg)  | reg_match(id_uses_rt, id_rt, ex_wreg);
      mem_dep_s = reg_match(id_uses_rs, id_rs, mem_wreg) | reg_match(id_uses_rt, id_rt, mem_wreg);
   end

   // Branch operands are compared in ID, so even ALU results in EX and loads in MEM are too late.
   always_comb begin
      hz_lu    = ex_memread & ex_regwrite & ex_dep_s;
      hz_br    = (id_branch | id_jumpr) & ((ex_regwrite & ex_dep_s) | (mem_memread & mem_dep_s));
      redirect = (id_branch & id_branch_taken) | id_jump | id_jumpr;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes, hazard stalls, memory-wait
// freezes, halt drain and saturating stall/flush performance counters.
module pipe_ctrl
   import ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_branch,
   input  logic             id_branch_taken,
   input  logic             id_jump,
   input  logic             id_jumpr,
   input  logic             id_halt,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [4:0]       ex_wreg,
   input  logic             mem_memread,
   input  logic [4:0]       mem_wreg,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   state_e            state_r, next_state_s;
   logic [DW-1:0]     drain_cnt_r, drain_next_s;
   logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
   logic              hz_lu_s, hz_br_s, redirect_s, freeze_s;
   logic              stall_inc_s, flush_inc_s;

   hazard_detect u_hazard (
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_branch       (id_branch),
      .id_branch_taken (id_branch_taken),
      .id_jump         (id_jump),
      .id_jumpr        (id_jumpr),
      .ex_regwrite     (ex_regwrite),
      .ex_memread      (ex_memread),
      .ex_wreg         (ex_wreg),
      .mem_memread     (mem_memread),
      .mem_wreg        (mem_wreg),
      .hz_lu           (hz_lu_s),
      .hz_br           (hz_br_s),
      .redirect        (redirect_s)
   );

   assign freeze_s = dmem_req & ~dmem_ready;

   // Next-state and per-stage control; a frozen cycle leaves everything still.
   always_comb begin
      next_state_s = state_r;
      drain_next_s = drain_cnt_r;
      stall_inc_s  = 1'b0;
      flush_inc_s  = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      halted       = 1'b0;
      case (state_r)
         BOOT: begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            next_state_s = RUN;
         end
         RUN: begin
            if (freeze_s) begin
               next_state_s = RUN;
            end else if (hz_lu_s | hz_br_s | id_halt) begin
               id_ex_en    = 1'b1;
               id_ex_flush = 1'b1;
               ex_mem_en   = 1'b1;
               mem_wb_en   = 1'b1;
               if (hz_lu_s | hz_br_s) begin
                  stall_inc_s = 1'b1;
               end else begin
                  drain_next_s = DW'(DRAIN_CYCLES);
                  next_state_s = DRAIN;
               end
            end else begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               id_ex_en    = 1'b1;
               ex_mem_en   = 1'b1;
               mem_wb_en   = 1'b1;
               if_id_flush = redirect_s;
               flush_inc_s = redirect_s;
            end
         end
         DRAIN: begin
            if (freeze_s) begin
               next_state_s = DRAIN;
            end else begin
               id_ex_en     = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_en    = 1'b1;
               mem_wb_en    = 1'b1;
               drain_next_s = drain_cnt_r - DW'(1);
               if (drain_cnt_r == DW'(1)) begin
                  next_state_s = HALTED;
               end else begin
                  next_state_s = DRAIN;
               end
            end
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            next_state_s = BOOT;
         end
      endcase
   end

   // Sequencer state and drain countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= BOOT;
         drain_cnt_r <= {DW{1'b0}};
      end else begin
         state_r     <= next_state_s;
         drain_cnt_r <= drain_next_s;
      end
   end

   // Performance counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan sequences then random episodes,
// checked against a cycle-level behavioural model; a 2-bit-counter copy checks saturation.
module tb_pipe_ctrl;

   localparam int DRAIN = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
   logic       id_uses_rs, id_uses_rt, id_branch, id_branch_taken, id_jump, id_jumpr, id_halt;
   logic       ex_regwrite, ex_memread, mem_memread, dmem_req, dmem_ready;

   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en, s_mem_wb_en, s_halted;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int errors = 0;
   int checks = 0;

   // model: mode 0=boot 1=run 2=drain 3=halted, drain cycles left, raw event counts
   int m     = 0;
   int left  = 0;
   int n_stall = 0;
   int n_flush = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
      .id_branch_taken(id_branch_taken), .id_jump(id_jump), .id_jumpr(id_jumpr),
      .id_halt(id_halt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_wreg(ex_wreg), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
      .id_branch_taken(id_branch_taken), .id_jump(id_jump), .id_jumpr(id_jumpr),
      .id_halt(id_halt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_wreg(ex_wreg), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
      .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
      .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .halted(s_halted),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit hit(input bit uses, input logic [4:0] src, input logic [4:0] dst);
      return uses && (src == dst) && (dst != 5'd0);
   endfunction

   function automatic bit reads(input logic [4:0] dst);
      return hit(id_uses_rs, id_rs, dst) || hit(id_uses_rt, id_rt, dst);
   endfunction

   function automatic bit stall_now();
      bit lu, br;
      lu = ex_memread && ex_regwrite && reads(ex_wreg);
      br = (id_branch || id_jumpr) &&
           ((ex_regwrite && reads(ex_wreg)) || (mem_memread && reads(mem_wreg)));
      return lu || br;
   endfunction

   function automatic bit redirect_now();
      return (id_branch && id_branch_taken) || id_jump || id_jumpr;
   endfunction

   function automatic bit frozen_now();
      return (m == 1 || m == 2) && dmem_req && !dmem_ready;
   endfunction

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted}
   function automatic logic [7:0] expect_out();
      if (m == 0) return 8'b0010_1000;
      if (m == 3) return 8'b0000_0001;
      if (frozen_now()) return 8'b0000_0000;
      if (m == 2) return 8'b0001_1110;
      if (stall_now() || id_halt) return 8'b0001_1110;
      if (redirect_now()) return 8'b1111_0110;
      return 8'b1101_0110;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic compare_all();
      logic [7:0] e;
      e = expect_out();
      check("ctl", {24'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted}, {24'd0, e});
      check("ctl_w2", {24'd0, s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en, s_mem_wb_en, s_halted}, {24'd0, e});
      check("stall_cnt", {16'd0, stall_cnt}, sat(n_stall, 65535));
      check("flush_cnt", {16'd0, flush_cnt}, sat(n_flush, 65535));
      check("stall_cnt_w2", {30'd0, s_stall_cnt}, sat(n_stall, 3));
      check("flush_cnt_w2", {30'd0, s_flush_cnt}, sat(n_flush, 3));
   endtask

   // Compare this cycle's outputs, then let the clock edge commit the model step.
   task automatic cycle();
      #2;
      compare_all();
      @(posedge clk);
      case (m)
         0: m = 1;
         1: if (!frozen_now()) begin
               if (stall_now()) n_stall++;
               else if (id_halt) begin m = 2; left = DRAIN; end
               else if (redirect_now()) n_flush++;
            end
         2: if (!frozen_now()) begin
               left--;
               if (left == 0) m = 3;
            end
         default: ;
      endcase
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      m = 0; left = 0; n_stall = 0; n_flush = 0;
      compare_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic clear();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0; id_jumpr = 1'b0; id_halt = 1'b0;
      ex_regwrite = 1'b0; ex_memread = 1'b0; ex_wreg = 5'd0;
      mem_memread = 1'b0; mem_wreg = 5'd0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic load_use();
      clear();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
   endtask

   task automatic rand_inputs();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_wreg = 5'($urandom_range(0, 3)); mem_wreg = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_branch = ($urandom_range(0, 3) == 0); id_branch_taken = 1'($urandom);
      id_jump = ($urandom_range(0, 7) == 0); id_jumpr = ($urandom_range(0, 7) == 0);
      id_halt = ($urandom_range(0, 39) == 0);
      ex_regwrite = 1'($urandom); ex_memread = ($urandom_range(0, 2) == 0);
      mem_memread = ($urandom_range(0, 2) == 0);
      dmem_req = ($urandom_range(0, 3) == 0); dmem_ready = 1'($urandom);
   endtask

   initial begin
      clear();
      @(posedge clk);
      #1;
      do_reset();
      cycle();                                   // BOOT cycle
      cycle();                                   // normal flow
      load_use(); cycle();                       // load-use stall
      clear(); cycle();
      id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
      cycle();                                   // BEQ after ADD stalls
      ex_wreg = 5'd0; cycle();                   // r0 never stalls
      id_branch_taken = 1'b1; cycle();           // taken branch flushes
      clear();
      load_use(); dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (3) cycle();                        // frozen over pending stall
      dmem_ready = 1'b1; cycle();
      load_use(); repeat (5) cycle();            // saturate 2-bit copy
      clear(); id_halt = 1'b1; cycle();
      clear(); dmem_req = 1'b1; cycle();         // freeze inside drain
      dmem_req = 1'b0; repeat (3) cycle();
      check("halted_after_drain", {31'd0, halted}, 32'd1);
      repeat (4) begin rand_inputs(); cycle(); end
      do_reset();
      cycle(); clear(); id_halt = 1'b1; cycle(); clear(); cycle();
      do_reset();                                // reset mid-drain
      for (int ep = 0; ep < 20; ep++) begin
         for (int c = 0; c < 150; c++) begin
            rand_inputs();
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
         end
         clear();
         do_reset();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It consumes decode-stage control (branch, jump, jumpr, halt) and EX/MEM destination info, and drives per-register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It owns load-use and branch-operand stalls, redirect flushes, data-memory wait freezes, the halt drain sequence, and saturating stall/flush counters.

Parameters:
DRAIN_CYCLES, 3, cycles to retire EX/MEM/WB contents after a halt is accepted in ID
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset; the polarity and synchronicity here are fixed
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  BEQ in ID
id_branch_taken  in  1  BEQ comparison true (valid only with id_branch)
id_jump  in  1  J/JAL in ID
id_jumpr  in  1  JR/JALR in ID
id_halt  in  1  HALT in ID (decoder load=0)
ex_regwrite  in  1  EX instruction writes a register
ex_memread  in  1  EX instruction is LW
ex_wreg  in  5  EX destination register
mem_memread  in  1  MEM instruction is LW
mem_wreg  in  5  MEM destination register
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_en  out  1  EX/MEM enable
mem_wb_en  out  1  MEM/WB enable
halted  out  1  core halted
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
flush_cnt  out  CNT_W  saturating count of redirect flushes

Behaviour:
- Single clock, clk. rst_n asynchronous, active-low. All flops reset: state=BOOT, drain_cnt=0, stall_cnt=0, flush_cnt=0.
- Outputs are combinational from state plus inputs. Counters are registered.
- States: BOOT, RUN, DRAIN, HALTED.
- BOOT: lasts exactly one cycle after rst_n rises. All enables 0; if_id_flush=1, id_ex_flush=1; halted=0. Then go to RUN.
- freeze = dmem_req & ~dmem_ready. Applies in RUN and DRAIN. All enables 0, all flushes 0, no counter or state change. Highest priority.
- hz_lu = ex_memread & ex_regwrite & ex_wreg!=0 & ((id_uses_rs & ex_wreg==id_rs) | (id_uses_rt & ex_wreg==id_rt)).
- hz_br = (id_branch|id_jumpr) & operand match (same rs/rt qualification, reg!=0) against either:
  - EX: ex_regwrite & ex_wreg, or
  - MEM: mem_memread & mem_wreg.
- stall = hz_lu | hz_br.
- redirect = (id_branch & id_branch_taken) | id_jump | id_jumpr.
- RUN, not frozen, priority stall > halt > redirect > normal:
  - stall: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=1; stall_cnt++.
  - id_halt: pc_en=0, if_id_en=0, id_ex_flush=1, downstream enables 1; load drain_cnt=DRAIN_CYCLES; go to DRAIN.
  - redirect: all enables 1, if_id_flush=1; flush_cnt++.
  - normal: all enables 1, flushes 0.
- DRAIN, not frozen: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. drain_cnt decrements. When drain_cnt==1 and the cycle is not frozen, go to HALTED. ID inputs are ignored.
- HALTED: all enables 0, flushes 0, halted=1. Exit only by reset.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation (any state, including mid-DRAIN) returns to BOOT immediately and clears the counters.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state encoding (BOOT=2'd0, RUN=2'd1, DRAIN=2'd2, HALTED=2'd3),
  - the REG_ZERO=5'd0 constant,
  - the default DRAIN_CYCLES.
- One combinational sub-module, hazard_detect, computes hz_lu, hz_br and redirect. It is reused by the future forwarding unit.

Test Plan:
- Reset release: rst_n 0->1 -> one cycle of all enables 0 with if_id_flush=id_ex_flush=1, then all enables 1, halted=0.
- Load-use: ex_memread=1, ex_regwrite=1, ex_wreg=8, id_rs=8, id_uses_rs=1 -> pc_en=if_id_en=0, id_ex_flush=1 for exactly that cycle; stall_cnt 0->1.
- BEQ after ADD: id_branch=1, id_rt=9, ex_regwrite=1, ex_wreg=9 -> stall; with ex_wreg=0 instead -> no stall. Then taken branch -> if_id_flush=1, flush_cnt+1.
- Freeze overrides: dmem_req=1, dmem_ready=0 for 3 cycles during a pending load-use -> all enables 0, flushes 0, stall_cnt unchanged. Stall applies on the cycle dmem_ready=1.
- Halt drain: id_halt=1 -> DRAIN. With one frozen cycle inserted, halted rises after 4 cycles (3 drain + 1 freeze). halted then stays 1 with all enables 0 despite further inputs.
- Saturation/reset: CNT_W=2, 5 stall cycles -> stall_cnt=3. Assert rst_n=0 mid-DRAIN -> counters 0, state BOOT.
